uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_pkg
// Brief    : Shared FSM state encoding and header-byte constant for the
//            UART transmit arbiter. The TAG state exists only when
//            UART_ARB_TAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef UART_ARB_TAG_EN
        ST_TAG  = 2'd1,
`endif
        ST_XFER = 2'd2
    } state_t;

    // Header byte base; the low bits carry the grantee index.
    localparam logic [7:0] C_TAG_BASE = 8'hF0;

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. Priority starts at the
//            requester after i_ptr and wraps modulo N_REQ; output is one-hot.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant
);

    logic [IW:0] w_idx;
    logic        w_found;

    // Scan from i_ptr+1 upward with wrap, first asserted request wins.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, i_ptr} + (IW+1)'(i + 1);
            if (w_idx >= (IW+1)'(N_REQ)) begin
                w_idx = w_idx - (IW+1)'(N_REQ);
            end
            if (!w_found && i_req[w_idx[IW-1:0]]) begin
                o_grant[w_idx[IW-1:0]] = 1'b1;
                w_found                = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter multiplexing N_REQ byte streams into one
//            UART transmit port with packet lock and MAX_BURST forced release.
//            Optional macro UART_ARB_TAG_EN inserts a header byte
//            (8'hF0 | grant_id) ahead of every grant.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    localparam int IW       = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic               busy,
    output logic [IW-1:0]      grant_id
);

    localparam int BW = $clog2(MAX_BURST + 1);

    state_t            r_state;
    logic [IW-1:0]     r_grant_id;
    logic [BW-1:0]     r_burst;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;

    logic [N_REQ-1:0]  w_grant;
    logic [IW-1:0]     w_win;
    logic              w_free;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [7:0]        w_sel_data;
    logic              w_accept;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_grant_id),
        .o_grant (w_grant)
    );

    // One-hot grant to index.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_win = IW'(i);
            end
        end
    end

    assign w_free      = !r_tx_valid || tx_ready;
    assign w_sel_valid = req_valid[r_grant_id];
    assign w_sel_last  = req_last[r_grant_id];
    assign w_sel_data  = req_data[r_grant_id*8 +: 8];
    assign w_accept    = (r_state == ST_XFER) && w_sel_valid && w_free;

    // Only the current grantee may see ready, and only while transferring.
    always_comb begin
        req_ready             = '0;
        req_ready[r_grant_id] = w_accept;
    end

    // Arbitration FSM, burst counter and output byte register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_id <= IW'(N_REQ - 1);
            r_burst    <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            // Drop valid after a handshake; a same-cycle load below overrides.
            if (r_tx_valid && tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_burst <= '0;
                    if (|req_valid) begin
                        r_grant_id <= w_win;
`ifdef UART_ARB_TAG_EN
                        r_state    <= ST_TAG;
`else
                        r_state    <= ST_XFER;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                ST_TAG: begin
                    // Header is emitted without consuming requester data.
                    if (w_free) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= C_TAG_BASE | {{(8-IW){1'b0}}, r_grant_id};
                        r_state    <= ST_XFER;
                    end
                end
`endif
                ST_XFER: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_sel_data;
                        if (w_sel_last || (r_burst == BW'(MAX_BURST - 1))) begin
                            r_state <= ST_IDLE;
                            r_burst <= '0;
                        end else begin
                            r_burst <= r_burst + BW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != ST_IDLE) || r_tx_valid;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] valid;
        logic [1:0] exp_gnt;
    } vec_t;

    vec_t vecs [12];

    uart_tx_arbiter #(
        .N_REQ     (4),
        .MAX_BURST (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rdy;
        logic        got;
        logic        done0;
        int          idx2;
        int          cyc;
        logic [7:0]  seen [$];
        logic [7:0]  exp_q [$];

        vecs[0]  = '{4'b1111, 2'd0};
        vecs[1]  = '{4'b1111, 2'd1};
        vecs[2]  = '{4'b1111, 2'd2};
        vecs[3]  = '{4'b1111, 2'd3};
        vecs[4]  = '{4'b1111, 2'd0};
        vecs[5]  = '{4'b1010, 2'd1};
        vecs[6]  = '{4'b1010, 2'd3};
        vecs[7]  = '{4'b1010, 2'd1};
        vecs[8]  = '{4'b0100, 2'd2};
        vecs[9]  = '{4'b1001, 2'd3};
        vecs[10] = '{4'b1001, 2'd0};
        vecs[11] = '{4'b0110, 2'd1};

        // ---------------- reset state, sampled while rst is held
        rst = 1'b1;
        tick();
        tick();
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 3);
        rst = 1'b0;

`ifndef UART_ARB_TAG_EN
        // ---------------- single byte, 2-cycle latency
        req_valid = 4'b0001;
        req_data  = 32'h0000_0041;
        req_last  = 4'b0001;
        tx_ready  = 1'b1;
        #1;
        check("idle_no_ready", 32'(req_ready), 0);
        tick();
        check("lat1_tx_valid", 32'(tx_valid), 0);
        check("lat1_grant", 32'(grant_id), 0);
        check("lat1_busy", 32'(busy), 1);
        check("xfer_ready", 32'(req_ready), 32'h1);
        tick();
        check("lat2_tx_valid", 32'(tx_valid), 1);
        check("lat2_tx_data", 32'(tx_data), 32'h41);
        req_valid = '0;
        tick();
        check("post_hs_tx_valid", 32'(tx_valid), 0);
        check("post_hs_busy", 32'(busy), 0);

        // ---------------- round-robin table, single-byte packets
        do_reset();
        req_data = 32'hA3A2_A1A0;
        req_last = 4'hF;
        for (int k = 0; k < 12; k++) begin
            req_valid = vecs[k].valid;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                #1;
                if (|req_ready) got = 1'b1;
                else tick();
            end
            check("rr_got_ready", 32'(got), 1);
            check("rr_ready", 32'(req_ready), 32'(4'b0001 << vecs[k].exp_gnt));
            check("rr_grant", 32'(grant_id), 32'(vecs[k].exp_gnt));
            tick();
            check("rr_tx_valid", 32'(tx_valid), 1);
            check("rr_tx_data", 32'(tx_data), 32'(8'hA0 + 8'(vecs[k].exp_gnt)));
        end
        req_valid = '0;
        tick();

        // ---------------- MAX_BURST forced release with competing requester
        do_reset();
        idx2  = 0;
        done0 = 1'b0;
        cyc   = 0;
        seen.delete();
        while (!(idx2 == 20 && done0 && !busy) && cyc < 200) begin
            req_valid[2]      = (idx2 < 20);
            req_data[23:16]   = 8'h60 + 8'(idx2);
            req_last[2]       = (idx2 == 19);
            req_valid[0]      = (idx2 >= 1) && !done0;
            req_data[7:0]     = 8'hC0;
            req_last[0]       = 1'b1;
            req_valid[1]      = 1'b0;
            req_valid[3]      = 1'b0;
            #1;
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy[2]) idx2++;
            if (rdy[0]) done0 = 1'b1;
            if (tx_valid) seen.push_back(tx_data);
            cyc++;
        end
        check("burst_finished", 32'(cyc < 200), 1);
        for (int b = 0; b < 16; b++) exp_q.push_back(8'h60 + 8'(b));
        exp_q.push_back(8'hC0);
        for (int b = 16; b < 20; b++) exp_q.push_back(8'h60 + 8'(b));
        check("burst_count", 32'(seen.size()), 21);
        for (int b = 0; b < 21 && b < seen.size(); b++) begin
            check("burst_byte", 32'(seen[b]), 32'(exp_q[b]));
        end
        req_valid = '0;
        tick();

        // ---------------- tx_ready back-pressure, replace-on-handshake
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_5500;
        req_last  = 4'b0000;
        tx_ready  = 1'b0;
        tick();
        check("stall_grant", 32'(grant_id), 1);
        tick();
        check("stall_first_valid", 32'(tx_valid), 1);
        check("stall_first_data", 32'(tx_data), 32'h55);
        req_data = 32'h0000_5600;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("stall_no_ready", 32'(req_ready), 0);
            tick();
            check("stall_valid_hold", 32'(tx_valid), 1);
            check("stall_data_hold", 32'(tx_data), 32'h55);
        end
        tx_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(req_ready), 32'h2);
        tick();
        check("replace_valid", 32'(tx_valid), 1);
        check("replace_data", 32'(tx_data), 32'h56);

        // ---------------- reset mid-packet with a held byte
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tx_valid", 32'(tx_valid), 0);
        check("midrst_grant", 32'(grant_id), 3);
        check("midrst_busy", 32'(busy), 0);
        tick();
        check("midrst_no_emit", 32'(tx_valid), 0);
        req_valid = '0;
        tick();
`else
        // ---------------- header byte ahead of data
        req_valid = 4'b0010;
        req_data  = 32'h0000_3000;
        req_last  = 4'b0010;
        tx_ready  = 1'b1;
        tick();
        check("tag_grant", 32'(grant_id), 1);
        check("tag_no_ready", 32'(req_ready), 0);
        check("tag_lat1_valid", 32'(tx_valid), 0);
        tick();
        check("tag_hdr_valid", 32'(tx_valid), 1);
        check("tag_hdr_data", 32'(tx_data), 32'hF1);
        tick();
        check("tag_data_valid", 32'(tx_valid), 1);
        check("tag_data", 32'(tx_data), 32'h30);
        req_valid = '0;
        tick();
        check("tag_done_valid", 32'(tx_valid), 0);
        check("tag_done_busy", 32'(busy), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
